// File: rtl/imm_pkg.sv
// Shared constants for the immediate decoder: format select codes, legal XLEN
// values and the shift-amount width helper.
package imm_pkg;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

  localparam int N_LEGAL_XLEN = 2;
  localparam int LEGAL_XLEN [N_LEGAL_XLEN] = '{32, 64};

  function automatic bit xlen_is_legal(input int xlen);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_XLEN; i++) begin
      if (LEGAL_XLEN[i] == xlen) ok = 1'b1;
    end
    return ok;
  endfunction

  // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
  function automatic int shamt_width(input int xlen);
    return (xlen == 64) ? 6 : 5;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: builds a 32-bit immediate per format,
// then sign- or zero-extends it to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            err
);

  localparam int SHAMT_W = shamt_width(XLEN);

  logic [31:0] imm32;
  logic        sext;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    sext  = 1'b1;
    err   = 1'b0;
    case (imm_src)
      IMM_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:  imm32 = {instr[31:12], 12'b0};
      IMM_Z: begin
        sext  = 1'b0;
        imm32 = {27'b0, instr[19:15]};
      end
      IMM_SH: begin
        sext                 = 1'b0;
        imm32[SHAMT_W-1:0]   = instr[20 +: SHAMT_W];
      end
      default: begin
        sext = 1'b0;
        err  = 1'b1;
      end
    endcase
  end

  // Every signed format fits in 32 bits, so widening is a plain sign extension.
  assign imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: one output register plus a one-entry skid
// register, so in_ready depends only on state and throughput stays at 1/cycle.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             imm_err,
  output logic [TAG_W-1:0] tag_out
);

  if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("imm_ext_pipe: TAG_W must be at least 1");
  end

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic             err;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;
  entry_t          dec_entry;

  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;
  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   accept, drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (dec_imm),
    .err     (dec_err)
  );

  assign dec_entry = '{imm: dec_imm, err: dec_err, tag: tag};

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & ~skid_valid_q;
  assign drain    = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_d        = out_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      if (drain) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || drain) begin
        out_d       = dec_entry;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = dec_entry;
        skid_valid_d = 1'b1;
      end
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_q        <= out_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign imm_ext   = out_q.imm;
  assign imm_err   = out_q.err;
  assign tag_out   = out_q.tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench: drives XLEN=32 and XLEN=64 instances with identical
// stimulus and checks both against hand-computed results in FIFO order.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic [4:0]  tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, imm_err32;
  logic [31:0] imm_ext32;
  logic [4:0]  tag_out32;
  logic        in_ready64, out_valid64, imm_err64;
  logic [63:0] imm_ext64;
  logic [4:0]  tag_out64;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_src(imm_src), .tag(tag), .out_valid(out_valid32),
    .out_ready(out_ready), .imm_ext(imm_ext32), .imm_err(imm_err32), .tag_out(tag_out32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_src(imm_src), .tag(tag), .out_valid(out_valid64),
    .out_ready(out_ready), .imm_ext(imm_ext64), .imm_err(imm_err64), .tag_out(tag_out64)
  );

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic        err;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;

  localparam int NV = 12;
  logic [31:0] v_instr [NV];
  logic [2:0]  v_src   [NV];
  logic [31:0] v_e32   [NV];
  logic [63:0] v_e64   [NV];
  logic        v_err   [NV];

  initial begin
    v_instr = '{32'hFFF00093, 32'hFE000EE3, 32'hFE000EE3, 32'h800000B7, 32'h800000B7, 32'h000F8073,
                32'h12345678, 32'h7FF00013, 32'h02500013, 32'hFFDFF06F, 32'h12345037, 32'h00000463};
    v_src   = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd6, 3'd3, 3'd4, 3'd2};
    v_e32   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFD, 32'h80000000, 32'h0, 32'h1F,
                32'h0, 32'h7FF, 32'h5, 32'hFFFFFFFC, 32'h12345000, 32'h8};
    v_e64   = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFFD,
                64'hFFFFFFFF_80000000, 64'h0, 64'h1F, 64'h0, 64'h7FF, 64'h25,
                64'hFFFFFFFF_FFFFFFFC, 64'h12345000, 64'h8};
    v_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops and compares on every drain, and checks output stability
  // across stalled cycles.
  initial begin
    logic        hold_pending;
    logic [31:0] hold_imm;
    logic [4:0]  hold_tag;
    exp_t        e;
    hold_pending = 1'b0;
    hold_imm     = '0;
    hold_tag     = '0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("stable_imm", 64'(imm_ext32), 64'(hold_imm));
          chk("stable_tag", 64'(tag_out32), 64'(hold_tag));
        end
        if (out_valid32 || out_valid64) chk("valid_match", 64'(out_valid64), 64'(out_valid32));
        if (out_valid32 && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual_tag=%0d required=none", tag_out32);
          end else begin
            e = sb_q.pop_front();
            $display("txn tag=%0d imm32=%h imm64=%h err=%0b", tag_out32, imm_ext32, imm_ext64, imm_err32);
            chk("imm32", 64'(imm_ext32), 64'(e.e32));
            chk("imm64", imm_ext64, e.e64);
            chk("err32", 64'(imm_err32), 64'(e.err));
            chk("err64", 64'(imm_err64), 64'(e.err));
            chk("tag32", 64'(tag_out32), 64'(e.tag));
            chk("tag64", 64'(tag_out64), 64'(e.tag));
            last_pop_cyc = cyc;
          end
        end
        hold_pending = out_valid32 && !out_ready;
        hold_imm     = imm_ext32;
        hold_tag     = tag_out32;
      end
    end
  end

  task automatic send(input int idx, input logic [4:0] t);
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    instr    = v_instr[idx];
    imm_src  = v_src[idx];
    tag      = t;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (in_ready32 && in_ready64) begin
        e.e32 = v_e32[idx];
        e.e64 = v_e64[idx];
        e.err = v_err[idx];
        e.tag = t;
        sb_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept tag=%0d", t);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int w = 0; w < 50 && sb_q.size() != 0; w++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  bit stream_done;
  localparam logic [15:0] READY_PAT = 16'b1011_0010_0111_0001;

  initial begin
    int c0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = '0;
    imm_src   = '0;
    tag       = '0;
    stream_done = 1'b0;

    #12;
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    chk("rst_imm32", 64'(imm_ext32), 64'd0);
    chk("rst_imm64", imm_ext64, 64'd0);
    chk("rst_err", 64'(imm_err32), 64'd0);
    chk("rst_tag", 64'(tag_out32), 64'd0);

    @(posedge clk);
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;

    // Directed vectors at full throughput; first one also checks latency.
    send(0, 5'd1);
    chk("latency1", 64'(out_valid32), 64'd1);
    c0 = cyc;
    for (int i = 1; i < NV; i++) send(i, 5'(i + 1));
    chk("throughput", 64'(cyc - c0), 64'(NV - 1));
    wait_drain();

    // Backpressure: tag 1 in output, tag 2 in skid, tag 3 stalls.
    out_ready = 1'b0;
    send(0, 5'd1);
    send(1, 5'd2);
    chk("skid_full_ready32", 64'(in_ready32), 64'd0);
    chk("skid_full_ready64", 64'(in_ready64), 64'd0);
    in_valid = 1'b1;
    instr    = 32'hDEADBEEF;
    imm_src  = 3'd7;
    tag      = 5'd31;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready32), 64'd0);
      chk("stall_head_tag", 64'(tag_out32), 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    c0 = cyc;
    send(3, 5'd3);
    wait_drain();
    chk("bp_consecutive", 64'(last_pop_cyc - c0), 64'd2);

    // Toggling out_ready while streaming the whole table.
    fork
      begin
        for (int i = 0; i < NV; i++) send(i, 5'(i + 20));
        stream_done = 1'b1;
      end
      begin
        int k = 0;
        while (!stream_done) begin
          @(posedge clk);
          #1;
          out_ready = READY_PAT[k % 16];
          k++;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    // Asynchronous reset with both registers full.
    out_ready = 1'b0;
    send(5, 5'd6);
    send(6, 5'd7);
    chk("pre_rst_full", 64'(in_ready32), 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid32", 64'(out_valid32), 64'd0);
    chk("arst_out_valid64", 64'(out_valid64), 64'd0);
    chk("arst_in_ready", 64'(in_ready32), 64'd1);
    chk("arst_imm32", 64'(imm_ext32), 64'd0);
    chk("arst_imm64", imm_ext64, 64'd0);
    chk("arst_tag", 64'(tag_out32), 64'd0);
    sb_q.delete();
    @(posedge clk);
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send(9, 5'd9);
    chk("post_rst_latency", 64'(out_valid32), 64'd1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised successor to the datapath immediate sign-extender, for the upcoming pipelined core.
- Decodes all RV immediate formats, including U, CSR zimm and shift-amount, to XLEN bits.
- Carries a sideband tag and uses a valid/ready handshake with a 2-entry skid buffer.
- Sits between the decode stage and the ID/EX register: latency 1 cycle, full throughput.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64 only (elaboration error otherwise).
- TAG_W, 5, width of the pass-through sideband tag (e.g. rd index); minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream request valid.
- in_ready  out  1  block can accept; registered, equals NOT skid_valid.
- instr  in  32  raw instruction word; bits [6:0] are ignored.
- imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SH, 111 reserved.
- tag  in  TAG_W  sideband, returned unchanged with its result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- imm_ext  out  XLEN  extended immediate.
- imm_err  out  1  set when imm_src was reserved.
- tag_out  out  TAG_W  tag that belongs to imm_ext.

Behaviour:
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Formats (s = instr[31] replicated to XLEN):
  - I: s, instr[31:20].
  - S: s, instr[31:25], instr[11:7].
  - B: s, instr[7], instr[30:25], instr[11:8], 0.
  - J: s, instr[19:12], instr[20], instr[30:21], 0.
  - U: s, instr[31:12], 12 zeros. For XLEN=64, bits 63:32 equal instr[31].
  - Z: zero-extended instr[19:15].
  - SH: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - Reserved (111): imm_ext = 0, imm_err = 1. imm_err is 0 for every other code.
- Storage: one output register (out_valid, imm_ext, imm_err, tag_out) plus one skid register holding the same fields and skid_valid.
- Per-cycle update, priority in order:
  1. skid_valid=1: in_ready is 0, so there is no accept. On drain, the output register loads the skid contents and skid_valid goes to 0. Without drain, nothing changes.
  2. skid_valid=0 and accept: if out_valid=0 or drain, the output register loads the new decode. Otherwise the new decode goes to skid and skid_valid goes to 1.
  3. skid_valid=0, no accept, drain: out_valid goes to 0.
- Ordering: strict FIFO order; no loss, no duplication.
- Output stability: output fields hold stable while out_valid=1 and out_ready=0.
- Upstream behaviour is unconstrained: in_valid may drop without acceptance, and instr/imm_src/tag may change while in_ready=0.
- Latency: a result appears on the outputs on the first clk edge after accept when the output register is free.
- Throughput: one result per cycle while out_ready stays 1.
- Reset (reset_n low, asynchronous, any time including mid-transfer):
  - out_valid=0, skid_valid=0, in_ready=1.
  - imm_ext=0, imm_err=0, tag_out=0, skid data cleared.
  - Any in-flight entries are discarded.
- Release of reset: the first accept may occur on the first clk edge after release.
- Combinational paths: none from out_ready to in_ready, and none from inputs to outputs.

Decomposition:
- Package imm_pkg:
  - localparams for the imm_src codes (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_RSV).
  - Constant list of legal XLEN values.
  - Function returning the shift-amount width for an XLEN.
- Sub-module imm_decode: purely combinational; instr, imm_src → imm, err; parameter XLEN.
- imm_ext_pipe instantiates imm_decode once and contains only the handshake and storage.

Test Plan:
- XLEN=32, instr=0xFFF00093, src=000, out_ready=1 → next cycle out_valid=1, imm_ext=0xFFFFFFFF, imm_err=0.
- XLEN=32, instr=0xFE000EE3, src=010 → imm_ext=0xFFFFFFFC. Same instr with src=001 → 0xFFFFFFFD.
- XLEN=64, instr=0x800000B7, src=100 → imm_ext=0xFFFFFFFF80000000. Same instr with src=110 → 0x0.
- src=101 with instr[19:15]=0x1F → 0x1F. src=111 → imm_ext=0, imm_err=1, tag_out equals tag.
- Backpressure: out_ready=0, send tags 1, 2, 3 on back-to-back cycles.
  - Tag 1 is in the output register, tag 2 in skid.
  - in_ready=0 from the cycle after tag 2 is accepted, so tag 3 stalls.
  - Raise out_ready → tags 1, 2, 3 emerge in order on consecutive cycles, with no duplicates.
- Reset mid-operation: with output and skid both full, pull reset_n low between edges → out_valid=0 and in_ready=1 immediately (no clk edge). After release, a new item flows with 1-cycle latency.
